// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI target slice: FSM encoding, command
// bit position, memory geometry and the default decode base.
package pci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SKIP,
        ST_DEVSEL,
        ST_DATA,
        ST_TURN
    } pci_state_e;

    localparam int          RW_BIT            = 0;
    localparam int          MEM_DEPTH         = 8;
    localparam int          PTR_W             = $clog2(MEM_DEPTH);
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_00A0;

    // Only AD[31:5] take part in the decode; the low bits select the word.
    function automatic logic addr_hit(input logic [26:0] ad_hi,
                                      input logic [26:0] base_hi);
        return ad_hi == base_hi;
    endfunction

endpackage

// File: rtl/pci_target_mem.sv
// 8x32 register file with byte-lane writes, one registered read port that
// feeds the bus and one combinational debug port.
module pci_target_mem
    import pci_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [31:0]      rdata_o,
    input  logic [PTR_W-1:0] dbg_addr_i,
    output logic [31:0]      dbg_data_o
);

    logic [31:0] mem_q [MEM_DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                for (int l = 0; l < 4; l++) begin
                    if (be_i[l]) begin
                        mem_q[waddr_i][8*l +: 8] <= wdata_i[8*l +: 8];
                    end
                end
            end
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o    = rdata_q;
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/pci_target.sv
// Simple PCI memory target: decodes a 32-byte window, inserts initial wait
// states (max(WAIT_STATES,1) DEVSEL cycles), then bursts with wrapping pointer.
module pci_target
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame,
    input  logic        irdy,
    input  logic [3:0]  C_BE,
    inout  wire  [31:0] AD,
    inout  wire         trdy,
    inout  wire         DevSel,
    output logic        trgt,
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    pci_state_e       state_q, state_d;
    logic             frame_q;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rw_q, rw_d;
    logic [1:0]       wcnt_q, wcnt_d;

    logic        addr_start;
    logic        hit;
    logic        xfer;
    logic        mem_we;
    logic [31:0] rdata;
    logic        trdy_val;
    logic        devsel_val;
    logic        ad_oe;
    logic        unused_ad;

    assign unused_ad  = ^AD[1:0];
    assign addr_start = !frame && frame_q;
    assign hit        = addr_hit(AD[31:5], BASE_ADDR[31:5]);
    assign xfer       = (state_q == ST_DATA) && !irdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            frame_q <= 1'b1;
            ptr_q   <= '0;
            rw_q    <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame;
            ptr_q   <= ptr_d;
            rw_q    <= rw_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (addr_start) state_d = hit ? ST_DEVSEL : ST_SKIP;
            ST_SKIP:   if (frame && irdy) state_d = ST_IDLE;
            ST_DEVSEL: if (wcnt_q <= 2'd1) state_d = ST_DATA;
            ST_DATA:   if (xfer && frame) state_d = ST_TURN;
            ST_TURN:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d  = ptr_q;
        rw_d   = rw_q;
        wcnt_d = wcnt_q;
        if (state_q == ST_IDLE && addr_start && hit) begin
            ptr_d  = AD[4:2];
            rw_d   = C_BE[RW_BIT];
            wcnt_d = 2'(WAIT_STATES);
        end else if (state_q == ST_DEVSEL && wcnt_q != 2'd0) begin
            wcnt_d = wcnt_q - 2'd1;
        end else if (xfer) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_comb begin
        trgt       = (state_q == ST_DEVSEL) || (state_q == ST_DATA) || (state_q == ST_TURN);
        trdy_val   = (state_q != ST_DATA);
        devsel_val = (state_q == ST_TURN);
        ad_oe      = (state_q == ST_DATA) && !rw_q;
    end

    assign trdy   = trgt  ? trdy_val   : 1'bz;
    assign DevSel = trgt  ? devsel_val : 1'bz;
    assign AD     = ad_oe ? rdata      : 32'bz;

    // The read port tracks the next pointer so data is ready one cycle ahead.
    assign mem_we = xfer && rw_q && !reset;

    pci_target_mem u_mem (
        .clk        (clk),
        .reset      (reset),
        .we_i       (mem_we),
        .be_i       (C_BE),
        .waddr_i    (ptr_q),
        .wdata_i    (AD),
        .raddr_i    (ptr_d),
        .rdata_o    (rdata),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

endmodule

// File: doc/pci_target.md
PCI_TARGET -- requirements
Module: pci_target

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_00A0; decode base, upper bits AD[31:5] compared.
REQ-002 Parameter WAIT_STATES, 2; initial-latency cycles in DEVSEL before first TRDY, range 0..3.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame  input  1  active-low bus FRAME from initiator.
REQ-006 irdy  input  1  active-low initiator ready.
REQ-007 C_BE  input  4  address phase: [0]=1 write, 0 read; data phase: byte enables, active-high per lane.
REQ-008 AD  inout  32  address in; read data driven by this block only in DATA state of a read, else 'z.
REQ-009 trdy  inout  1  active-low target ready; driven only while selected or in TURN, else 'z.
REQ-010 DevSel  inout  1  active-low device select; same drive window as trdy.
REQ-011 trgt  output  1  high while this block owns trdy/DevSel (DEVSEL, DATA, TURN).
REQ-012 dbg_addr  input  3  sideband memory read index; dbg_data  output  32  mem[dbg_addr], combinational.

Function
REQ-013 States IDLE, SKIP, DEVSEL, DATA, TURN; frame_q registers frame each cycle.
REQ-014 IDLE: frame==0 && frame_q==1 && AD[31:5]==BASE_ADDR[31:5] -> DEVSEL; latch ptr=AD[4:2], rw=C_BE[0], wcnt=WAIT_STATES.
REQ-015 IDLE: address start with decode miss -> SKIP; SKIP -> IDLE when frame==1 && irdy==1.
REQ-016 DEVSEL: drive DevSel=0, trdy=1, AD='z; wcnt decrements per cycle; wcnt==0 -> DATA (WAIT_STATES=0 gives one DEVSEL cycle).
REQ-017 DATA: drive DevSel=0, trdy=0; on read drive AD=mem[ptr] registered, updated the cycle after each transfer.
REQ-018 Transfer occurs on posedge where irdy==0 && trdy==0 in DATA; irdy==1 inserts initiator wait, state held, nothing changes.
REQ-019 Write transfer: for each lane i with C_BE[i]==1, mem[ptr][8i+7:8i]<=AD lane; lanes with C_BE[i]==0 unchanged.
REQ-020 Each transfer: ptr<=ptr+1 mod 8 (burst wraps 7->0, no error).
REQ-021 Transfer with frame==1 is the last phase -> TURN; transfer with frame==0 stays in DATA.
REQ-022 TURN: drive trdy=1, DevSel=1, AD='z for exactly one cycle, then IDLE releases trdy/DevSel to 'z.
REQ-023 frame deasserting during DEVSEL does not abort; block completes exactly one data phase.
REQ-024 New address phase is not accepted in TURN; earliest next decode is the cycle after TURN.
REQ-025 No timeout: DATA with irdy held high waits indefinitely.

Reset
REQ-026 reset==1 at posedge: state=IDLE, ptr=0, wcnt=0, rw=0, frame_q=1, all mem words=32'h0.
REQ-027 Outputs after reset edge: AD='z, trdy='z, DevSel='z, trgt=0; reset mid-burst releases bus on that edge, no write committed in that cycle.

Structure
REQ-028 Package pci_pkg holds state enumeration, C_BE[0] read/write bit position, MEM_DEPTH=8, default BASE_ADDR.
REQ-029 Sub-module pci_target_mem: 8x32 register file, byte-lane write enable, one registered read port, one combinational debug port.

Verification
REQ-030 Write burst 3 to 32'hA0, C_BE=4'b0001, data 11111111/22222222/33333333, BE=4'hF -> mem[0..2] equal data; DevSel low 2 cycles before first trdy low.
REQ-031 Read burst 2 at 32'hA4 after REQ-030 -> AD returns 22222222 then 33333333; TURN cycle shows trdy=DevSel=1, then 'z.
REQ-032 Single write 32'hFFFFFFFF to 32'hA0 with BE=4'b1001 over mem[0]=11111111 -> mem[0]=FF1111FF.
REQ-033 Write burst 4 starting 32'hB8 (ptr 6) -> words land in mem[6],mem[7],mem[0],mem[1].
REQ-034 Address 32'hC0 (miss) -> trgt stays 0, trdy/DevSel stay 'z, mem unchanged; following hit decoded normally.
REQ-035 Assert reset during DATA of a write burst with irdy=0 -> bus released on that edge, that word not written, state IDLE.
